// File: rtl/rsa_pkg.sv
// rsa_pkg: shared RSA sizing constants and the mont_setup state encoding.
package rsa_pkg;
  localparam int RSA_WIDTH = 256;
  localparam int RSA_WORD = 32;
  typedef enum logic [1:0] {IDLE, CALC_R, CALC_R2, FINISH} ms_state_t;
endpackage

// File: rtl/mont_inv_word.sv
// mont_inv_word: Hensel-lifting engine, one bit per cycle, yielding -n^-1 mod 2^WORD.
module mont_inv_word #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WORD-1:0] n,
  output logic            done,
  output logic [WORD-1:0] mp
);
  localparam int IW = $clog2(WORD);
  logic [WORD-1:0] nl, y, prod, y_nx;
  logic [IW-1:0] i;
  logic active;
  assign prod = nl * y;
  assign y_nx = prod[i] ? y + (WORD'(1) << i) : y;
  assign done = active && i == IW'(WORD - 1);
  assign mp = (~y_nx) + WORD'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nl <= '0;
      y <= '0;
      i <= '0;
      active <= 1'b0;
    end else if (start) begin
      nl <= n;
      y <= WORD'(1);
      i <= IW'(1);
      active <= 1'b1;
    end else if (active) begin
      y <= y_nx;
      i <= i + IW'(1);
      active <= !done;
    end
  end
endmodule

// File: rtl/mont_setup.sv
// mont_setup: bit-serial Montgomery constant precompute (mp, r_mod, optional r2_mod).
// Define MONT_SETUP_R2_EN to also compute r2_mod = 2^(2*WIDTH) mod N.
module mont_setup
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int WORD = RSA_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WORD-1:0]  mp,
  output logic [WIDTH-1:0] r_mod,
  output logic [WIDTH-1:0] r2_mod
);
  localparam int CW = $clog2(2 * WIDTH) + 1;
  if (WORD - 1 >= WIDTH) begin : g_chk
    $error("mont_setup: WORD-1 must be less than WIDTH");
  end
  ms_state_t state, state_nx;
  logic [WIDTH-1:0] n, acc, red;
  logic [WIDTH:0] t;
  logic [CW-1:0] cnt;
  logic accept, valid, last_r, inv_done;
  logic [WORD-1:0] inv_mp;
  assign accept = state == IDLE && start;
  assign valid = modulus[0] && modulus != WIDTH'(1);
  assign t = {acc, 1'b0};
  // acc < N always holds, so a single conditional subtract fully reduces 2*acc
  assign red = t >= {1'b0, n} ? WIDTH'(t - {1'b0, n}) : t[WIDTH-1:0];
  assign last_r = cnt == CW'(WIDTH - 1);
  mont_inv_word #(.WORD(WORD)) u_inv (
    .clk(clk),
    .rst(rst),
    .start(accept && valid),
    .n(modulus[WORD-1:0]),
    .done(inv_done),
    .mp(inv_mp)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
`ifdef MONT_SETUP_R2_EN
  logic last_r2;
  assign last_r2 = cnt == CW'(2 * WIDTH - 1);
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? (valid ? CALC_R : FINISH) : IDLE;
      CALC_R:  state_nx = last_r ? CALC_R2 : CALC_R;
      CALC_R2: state_nx = last_r2 ? FINISH : CALC_R2;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r2_mod <= '0;
    else if (accept) r2_mod <= '0;
    else if (state == CALC_R2 && last_r2) r2_mod <= red;
  end
`else
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? (valid ? CALC_R : FINISH) : IDLE;
      CALC_R:  state_nx = last_r ? FINISH : CALC_R;
      default: state_nx = IDLE;
    endcase
  end
  assign r2_mod = '0;
`endif
  always_comb begin
    busy = state != IDLE;
    done = state == FINISH;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= '0;
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
      mp <= '0;
      r_mod <= '0;
    end else if (accept) begin
      n <= modulus;
      acc <= WIDTH'(1);
      cnt <= '0;
      err <= !valid;
      mp <= '0;
      r_mod <= '0;
    end else begin
      if (inv_done) mp <= inv_mp;
      if (state == CALC_R || state == CALC_R2) begin
        acc <= red;
        cnt <= cnt + CW'(1);
      end
      if (state == CALC_R && last_r) r_mod <= red;
    end
  end
endmodule

// File: tb/tb_mont_setup.sv
// tb_mont_setup: table vectors, hand sequences and random odd moduli against a bignum model.
module tb_mont_setup;
  localparam int W = 256;
  localparam int WD = 32;
`ifdef MONT_SETUP_R2_EN
  localparam int LAT = 2 * W + 1;
  localparam bit R2 = 1'b1;
`else
  localparam int LAT = W + 1;
  localparam bit R2 = 1'b0;
`endif
  typedef struct {
    logic [W-1:0]  n;
    logic [WD-1:0] mp;
    logic [W-1:0]  r;
    logic [W-1:0]  r2;
    logic          err;
    int            due;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] modulus = '0;
  logic busy, done, err;
  logic [WD-1:0] mp;
  logic [W-1:0] r_mod, r2_mod;
  exp_t q[$];
  exp_t tbl[8];
  int checks = 0, passed = 0, cyc = 0, done_cnt = 0;

  mont_setup dut (
    .clk(clk), .rst(rst), .start(start), .modulus(modulus),
    .busy(busy), .done(done), .err(err), .mp(mp), .r_mod(r_mod), .r2_mod(r2_mod)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] pow_mod(input int e, input logic [W-1:0] n);
    logic [2*W+8:0] p;
    p = '0;
    p[e] = 1'b1;
    return W'(p % (2*W+9)'(n));
  endfunction

  // Newton iteration for the inverse, independent of the bit-serial Hensel scheme
  function automatic logic [WD-1:0] mp_model(input logic [WD-1:0] n);
    logic [WD-1:0] x;
    x = n;
    for (int k = 0; k < 5; k++) x = x * (WD'(2) - n * x);
    return -x;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      done_cnt++;
      chk("busy_at_done", W'(busy), W'(1));
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 want no done at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("mp", W'(mp), W'(e.mp));
        chk("r_mod", r_mod, e.r);
        chk("r2_mod", r2_mod, e.r2);
        chk("err", W'(err), W'(e.err));
        chk("latency", W'(cyc), W'(e.due));
      end
    end
  end

  task automatic wait_empty(input int lim);
    int k = 0;
    while (q.size() != 0 && k < lim) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL timeout: got no done within %0d cycles want done", lim);
      q.delete();
    end
  endtask

  task automatic issue(input exp_t e_in);
    exp_t e;
    e = e_in;
    if (!R2) e.r2 = '0;
    @(negedge clk);
    e.due = cyc + (e.err ? 1 : LAT);
    q.push_back(e);
    start = 1'b1;
    modulus = e.n;
    @(negedge clk);
    start = 1'b0;
    modulus = rnd_word();
  endtask

  task automatic run(input exp_t e);
    issue(e);
    wait_empty(LAT + 10);
  endtask

  function automatic exp_t model(input logic [W-1:0] n);
    exp_t e;
    e.n = n;
    e.mp = mp_model(n[WD-1:0]);
    e.r = pow_mod(W, n);
    e.r2 = pow_mod(2 * W, n);
    e.err = 1'b0;
    e.due = 0;
    return e;
  endfunction

  initial begin
    exp_t e;
    int d0;
    logic [W-1:0] n;
    tbl[0] = '{{W{1'b1}}, 32'h00000001, W'(1), W'(1), 1'b0, 0};
    tbl[1] = '{W'(7), 32'h49249249, W'(2), W'(4), 1'b0, 0};
    tbl[2] = '{W'(3), 32'h55555555, W'(1), W'(1), 1'b0, 0};
    tbl[3] = '{W'(4), 32'h0, W'(0), W'(0), 1'b1, 0};
    tbl[4] = '{W'(1), 32'h0, W'(0), W'(0), 1'b1, 0};
    tbl[5] = '{W'(5), 32'h33333333, W'(1), W'(1), 1'b0, 0};
    tbl[6] = '{W'(2), 32'h0, W'(0), W'(0), 1'b1, 0};
    tbl[7] = '{W'(0), 32'h0, W'(0), W'(0), 1'b1, 0};
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_err", W'(err), '0);
    chk("rst_mp", W'(mp), '0);
    chk("rst_r_mod", r_mod, '0);
    chk("rst_r2_mod", r2_mod, '0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run(tbl[i]);
    // start pulsed mid-run and again in the done cycle must both be ignored
    d0 = done_cnt;
    issue(tbl[2]);
    repeat (50) @(negedge clk);
    start = 1'b1;
    modulus = W'(5);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < LAT + 5 && !done; k++) @(negedge clk);
    start = 1'b1;
    modulus = W'(4);
    @(negedge clk);
    start = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    chk("single_done", W'(done_cnt - d0), W'(1));
    chk("idle_after", W'(busy), '0);
    wait_empty(1);
    // reset at iteration 100 aborts with no done pulse
    d0 = done_cnt;
    issue(tbl[1]);
    repeat (99) @(negedge clk);
    chk("busy_mid", W'(busy), W'(1));
    chk("mp_mid", W'(mp), W'(32'h49249249));
    rst = 1'b1;
    #1;
    q.delete();
    chk("abort_busy", W'(busy), '0);
    chk("abort_mp", W'(mp), '0);
    chk("abort_r_mod", r_mod, '0);
    chk("abort_err", W'(err), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    chk("abort_no_done", W'(done_cnt - d0), '0);
    run(tbl[1]);
    for (int i = 0; i < 100; i++) begin
      n = rnd_word();
      n[0] = 1'b1;
      if (n == W'(1)) n = W'(3);
      e = model(n);
      run(e);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
